// File: rtl/snake_vga_pkg.sv
// Shared types and grid constants for the snake VGA tile path.
package snake_vga_pkg;

  localparam int CELL_W      = 4;
  localparam int GRID_COLS   = 32;
  localparam int GRID_ROWS   = 24;
  localparam int TILE_ADDR_W = 10;
  localparam int ROW_W       = 5;
  localparam int COL_W       = 5;

  localparam logic [ROW_W-1:0]       LAST_ROW  = ROW_W'(GRID_ROWS - 1);
  localparam logic [TILE_ADDR_W-1:0] LAST_TILE = TILE_ADDR_W'(GRID_ROWS * GRID_COLS - 1);

  typedef logic [CELL_W-1:0] tile_t;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    tile_t            data;
  } cell_req_t;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } bw_state_t;

  // Rows are exactly 32 tiles wide, so the linear address is a plain concatenation.
  function automatic logic [TILE_ADDR_W-1:0] tile_addr(input logic [ROW_W-1:0] row,
                                                       input logic [COL_W-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/board_writer_req_fifo.sv
// Synchronous request FIFO of cell_req_t; DEPTH must be a power of two and at least 2.
module req_fifo
  import snake_vga_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  cell_req_t               wr_data,
  output cell_req_t               rd_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = $clog2(DEPTH);

  cell_req_t        mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             push_s;
  logic             pop_s;

  assign full    = (count_r == (PTR_W + 1)'(DEPTH));
  assign empty   = (count_r == {(PTR_W + 1){1'b0}});
  assign count   = count_r;
  assign rd_data = mem_r[rd_ptr_r];
  assign push_s  = push & ~full;
  assign pop_s   = pop & ~empty;

  // Pointer and occupancy tracking; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W + 1){1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (PTR_W + 1)'(1);
        2'b01:   count_r <= count_r - (PTR_W + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= wr_data;
  end

endmodule

// File: rtl/board_writer.sv
// Tile RAM write agent: buffers cell updates and runs full-board clears.
// Optional BOARD_WRITER_VBLANK_GATE_EN restricts writes to blanking intervals.
module board_writer
  import snake_vga_pkg::*;
#(
  parameter int    FIFO_DEPTH = 4,
  parameter tile_t CLEAR_VAL  = 4'h0
) (
  input  logic                   clk,
  input  logic                   reset,
`ifdef BOARD_WRITER_VBLANK_GATE_EN
  input  logic                   in_vblank,
`endif
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ROW_W-1:0]       req_row,
  input  logic [COL_W-1:0]       req_col,
  input  logic [CELL_W-1:0]      req_data,
  input  logic                   clear_start,
  output logic                   clear_done,
  output logic                   busy,
  output logic                   oob_err,
  output logic                   we,
  output logic [TILE_ADDR_W-1:0] waddr,
  output logic [CELL_W-1:0]      wdata
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  bw_state_t              state_r, state_s;
  logic [TILE_ADDR_W-1:0] cnt_r, cnt_s;
  logic [TILE_ADDR_W-1:0] waddr_r, waddr_s;
  tile_t                  wdata_r, wdata_s;
  logic                   we_r, we_s;
  logic                   done_r, done_s;
  logic                   oob_r, oob_s;
  logic                   pop_s;
  logic                   push_s;
  logic                   advance_s;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;
  logic [CNT_W-1:0]       fifo_count_s;
  cell_req_t              head_s;
  cell_req_t              in_req_s;

`ifdef BOARD_WRITER_VBLANK_GATE_EN
  assign advance_s = in_vblank;
`else
  assign advance_s = 1'b1;
`endif

  assign req_ready = reset & ~fifo_full_s;
  assign push_s    = req_valid & req_ready;
  assign in_req_s  = '{row: req_row, col: req_col, data: req_data};

  req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push_s),
    .pop     (pop_s),
    .wr_data (in_req_s),
    .rd_data (head_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (fifo_count_s)
  );

  // Next-state and next-output decode; the clear's first write is issued on the start edge itself.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    we_s    = 1'b0;
    waddr_s = waddr_r;
    wdata_s = wdata_r;
    done_s  = 1'b0;
    oob_s   = oob_r;
    pop_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (clear_start) begin
          state_s = CLEAR;
          if (advance_s) begin
            we_s    = 1'b1;
            waddr_s = {TILE_ADDR_W{1'b0}};
            wdata_s = CLEAR_VAL;
            cnt_s   = TILE_ADDR_W'(1);
          end else begin
            cnt_s   = {TILE_ADDR_W{1'b0}};
          end
        end else if (advance_s && !fifo_empty_s) begin
          pop_s = 1'b1;
          if (head_s.row > LAST_ROW) begin
            oob_s = 1'b1;
          end else begin
            we_s    = 1'b1;
            waddr_s = tile_addr(head_s.row, head_s.col);
            wdata_s = head_s.data;
          end
        end else begin
          pop_s = 1'b0;
        end
      end
      CLEAR: begin
        if (advance_s) begin
          we_s    = 1'b1;
          waddr_s = cnt_r;
          wdata_s = CLEAR_VAL;
          if (cnt_r == LAST_TILE) begin
            state_s = IDLE;
            done_s  = 1'b1;
            cnt_s   = {TILE_ADDR_W{1'b0}};
          end else begin
            cnt_s   = cnt_r + TILE_ADDR_W'(1);
          end
        end else begin
          we_s = 1'b0;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
      cnt_r   <= {TILE_ADDR_W{1'b0}};
      we_r    <= 1'b0;
      waddr_r <= {TILE_ADDR_W{1'b0}};
      wdata_r <= {CELL_W{1'b0}};
      done_r  <= 1'b0;
      oob_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      we_r    <= we_s;
      waddr_r <= waddr_s;
      wdata_r <= wdata_s;
      done_r  <= done_s;
      oob_r   <= oob_s;
    end
  end

  assign we         = we_r;
  assign waddr      = waddr_r;
  assign wdata      = wdata_r;
  assign clear_done = done_r;
  assign oob_err    = oob_r;
  assign busy       = (state_r == CLEAR) | (fifo_count_s != {CNT_W{1'b0}}) | we_r;

endmodule

// File: tb/tb_board_writer.sv
// Self-checking bench for board_writer: random cell traffic scored against a queue model.
module tb_board_writer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [4:0] req_row = 5'd0;
  logic [4:0] req_col = 5'd0;
  logic [3:0] req_data = 4'h0;
  logic       clear_start = 1'b0;
  logic       clear_done;
  logic       busy;
  logic       oob_err;
  logic       we;
  logic [9:0] waddr;
  logic [3:0] wdata;
`ifdef BOARD_WRITER_VBLANK_GATE_EN
  logic       in_vblank = 1'b1;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Expected writes in issue order: {address, data}.
  logic [13:0] exp_q[$];

  board_writer #(.FIFO_DEPTH(4), .CLEAR_VAL(4'h0)) dut (
    .clk         (clk),
    .reset       (reset),
`ifdef BOARD_WRITER_VBLANK_GATE_EN
    .in_vblank   (in_vblank),
`endif
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_row     (req_row),
    .req_col     (req_col),
    .req_data    (req_data),
    .clear_start (clear_start),
    .clear_done  (clear_done),
    .busy        (busy),
    .oob_err     (oob_err),
    .we          (we),
    .waddr       (waddr),
    .wdata       (wdata)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) tick();
    vectors++;
    if (req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready_low: got %b expected 0", req_ready);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if ({we, clear_done, oob_err, busy, req_ready, waddr, wdata} !== {5'b00001, 10'd0, 4'h0}) begin
      miscompares++;
      $display("FAIL reset_state: we=%b done=%b oob=%b busy=%b ready=%b waddr=%0d wdata=%h expected 0 0 0 0 1 0 0",
               we, clear_done, oob_err, busy, req_ready, waddr, wdata);
    end
  endtask

  task automatic test_single;
    req_valid = 1'b1; req_row = 5'd5; req_col = 5'd7; req_data = 4'hA;
    tick();
    req_valid = 1'b0;
    vectors++;
    if ({we, busy} !== 2'b01) begin
      miscompares++;
      $display("FAIL single_accept: we=%b busy=%b expected we=0 busy=1", we, busy);
    end
    tick();
    vectors++;
    if ({we, waddr, wdata} !== {1'b1, 10'd167, 4'hA}) begin
      miscompares++;
      $display("FAIL single_write: we=%b waddr=%0d wdata=%h expected 1 167 a", we, waddr, wdata);
    end
    tick();
    vectors++;
    if ({we, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL single_after: we=%b busy=%b expected 0 0", we, busy);
    end
  endtask

  task automatic test_random_traffic;
    logic pending = 1'b0;
    logic fire;
    logic [13:0] e;
    exp_q.delete();
    for (int c = 0; c < 400; c++) begin
      if (!pending) begin
        req_valid = ($urandom_range(0, 2) != 0) && (c < 380);
        req_row   = 5'($urandom_range(0, 23));
        req_col   = 5'($urandom_range(0, 31));
        req_data  = 4'($urandom);
      end
      fire = req_valid && req_ready;
      if (fire) exp_q.push_back({10'(req_row * 32 + req_col), req_data});
      tick();
      pending = req_valid && !fire;
      if (we) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL rand_extra_write: waddr=%0d wdata=%h expected no write", waddr, wdata);
        end else begin
          e = exp_q.pop_front();
          if ({waddr, wdata} !== e) begin
            miscompares++;
            $display("FAIL rand_write: waddr=%0d wdata=%h expected %0d %h", waddr, wdata, e[13:4], e[3:0]);
          end
        end
      end
    end
    req_valid = 1'b0;
    vectors++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rand_drain: %0d writes missing, busy=%b expected 0 0", exp_q.size(), busy);
    end
  endtask

  task automatic test_back_to_back;
    logic [13:0] reqs[6];
    logic [13:0] e;
    int idx = 0;
    int n = 0;
    exp_q.delete();
    for (int k = 0; k < 6; k++) reqs[k] = {5'($urandom_range(0, 23)), 5'($urandom), 4'($urandom)};
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      req_valid = 1'b1;
      {req_row, req_col, req_data} = reqs[idx];
      if (req_ready) begin
        exp_q.push_back(reqs[idx]);
        idx++;
      end
      tick();
    end
    req_valid = 1'b0;
    vectors++;
    if (idx != 4 || req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_full: accepts=%0d ready=%b expected 4 0", idx, req_ready);
    end
    while (clear_done !== 1'b1 && n < 800) begin
      tick();
      n++;
    end
    vectors++;
    if ({clear_done, we, waddr} !== {2'b11, 10'd767}) begin
      miscompares++;
      $display("FAIL b2b_clear_end: done=%b we=%b waddr=%0d expected 1 1 767", clear_done, we, waddr);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      e = exp_q.pop_front();
      vectors++;
      if ({we, waddr, wdata} !== {1'b1, e}) begin
        miscompares++;
        $display("FAIL b2b_write%0d: we=%b waddr=%0d wdata=%h expected 1 %0d %h", k, we, waddr, wdata, e[13:4], e[3:0]);
      end
    end
    tick();
    vectors++;
    if ({we, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL b2b_idle: we=%b busy=%b expected 0 0", we, busy);
    end
  endtask

  task automatic test_clear;
    clear_start = 1'b1;
    tick();
    for (int i = 0; i < 768; i++) begin
      vectors++;
      if ({we, waddr, wdata, clear_done} !== {1'b1, 10'(i), 4'h0, (i == 767)}) begin
        miscompares++;
        $display("FAIL clear_cycle%0d: we=%b waddr=%0d wdata=%h done=%b expected 1 %0d 0 %b",
                 i, we, waddr, wdata, clear_done, i, (i == 767));
      end
      clear_start = (i == 100);
      tick();
    end
    clear_start = 1'b0;
    vectors++;
    if ({we, clear_done, busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL clear_end: we=%b done=%b busy=%b expected 0 0 0", we, clear_done, busy);
    end
  endtask

  task automatic test_oob;
    logic [4:0] r;
    logic [4:0] cl;
    logic [3:0] d;
    req_valid = 1'b1; req_row = 5'd24; req_col = 5'd3; req_data = 4'($urandom);
    tick();
    req_valid = 1'b0;
    tick();
    vectors++;
    if ({we, oob_err} !== 2'b01) begin
      miscompares++;
      $display("FAIL oob_drop: we=%b oob=%b expected 0 1", we, oob_err);
    end
    r = 5'($urandom_range(0, 23)); cl = 5'($urandom); d = 4'($urandom);
    req_valid = 1'b1; req_row = r; req_col = cl; req_data = d;
    tick();
    req_valid = 1'b0;
    tick();
    vectors++;
    if ({we, waddr, wdata, oob_err} !== {1'b1, 10'(r * 32 + cl), d, 1'b1}) begin
      miscompares++;
      $display("FAIL oob_next_write: we=%b waddr=%0d wdata=%h oob=%b expected 1 %0d %h 1",
               we, waddr, wdata, oob_err, r * 32 + cl, d);
    end
    repeat (5) tick();
    vectors++;
    if (oob_err !== 1'b1) begin
      miscompares++;
      $display("FAIL oob_sticky: got %b expected 1", oob_err);
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    vectors++;
    if (oob_err !== 1'b0) begin
      miscompares++;
      $display("FAIL oob_reset: got %b expected 0", oob_err);
    end
  endtask

  task automatic test_reset_mid_clear;
    int bad = 0;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      req_valid = (i < 2);
      req_row = 5'($urandom_range(0, 23)); req_col = 5'($urandom); req_data = 4'($urandom);
      tick();
    end
    req_valid = 1'b0;
    vectors++;
    if ({we, waddr} !== {1'b1, 10'd100}) begin
      miscompares++;
      $display("FAIL midclr_pos: we=%b waddr=%0d expected 1 100", we, waddr);
    end
    reset = 1'b0;
    tick();
    vectors++;
    if ({we, clear_done, busy, req_ready} !== 4'b0000) begin
      miscompares++;
      $display("FAIL midclr_reset: we=%b done=%b busy=%b ready=%b expected 0 0 0 0", we, clear_done, busy, req_ready);
    end
    reset = 1'b1;
    for (int i = 0; i < 800; i++) begin
      tick();
      if (we || clear_done || busy) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL midclr_quiet: %0d active cycles expected 0", bad);
    end
  endtask

`ifdef BOARD_WRITER_VBLANK_GATE_EN
  task automatic test_vblank;
    int exp_addr = 0;
    logic vb_prev;
    for (int c = 0; c < 4000 && clear_done !== 1'b1; c++) begin
      clear_start = (c == 0);
      in_vblank = 1'($urandom_range(0, 1));
      vb_prev = in_vblank;
      tick();
      vectors++;
      if (we !== vb_prev || (we && waddr !== 10'(exp_addr))) begin
        miscompares++;
        $display("FAIL vblank_cycle%0d: we=%b waddr=%0d expected %b %0d", c, we, waddr, vb_prev, exp_addr);
      end
      if (we) exp_addr++;
    end
    clear_start = 1'b0;
    in_vblank = 1'b1;
    vectors++;
    if (exp_addr != 768) begin
      miscompares++;
      $display("FAIL vblank_total: %0d writes expected 768", exp_addr);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_random_traffic();
    test_back_to_back();
    test_clear();
    test_oob();
    test_reset_mid_clear();
`ifdef BOARD_WRITER_VBLANK_GATE_EN
    test_vblank();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/board_writer.md
Name: board_writer

Overview:
- Write-side agent for the dual-port tile RAM that the VGA scan-out controller reads through raddr/re.
- Accepts cell-update requests from game logic over a valid/ready handshake and buffers them in a small FIFO.
- Converts each (row, col) request to a linear tile address and issues one registered write per cycle.
- Also runs a full-board clear sequence on command.

Parameters:
- CELL_W, 4, bits per tile entry (colour/tile code).
- GRID_COLS, 32, tiles per row; fixed at 32 so the address is {row, col}.
- GRID_ROWS, 24, valid tile rows (640x480 with 20 px tiles).
- FIFO_DEPTH, 4, request FIFO entries; must be a power of 2 and at least 2.
- CLEAR_VAL, 0, tile value written during a clear.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  FIFO can accept a request.
- req_row  in  5  tile row, 0..GRID_ROWS-1.
- req_col  in  5  tile column, 0..31.
- req_data  in  CELL_W  tile value.
- clear_start  in  1  one-cycle pulse that starts a board clear.
- clear_done  out  1  one-cycle pulse when the clear completes.
- busy  out  1  clear active, FIFO non-empty, or write in flight.
- oob_err  out  1  sticky flag: a request with row >= GRID_ROWS was dropped.
- we  out  1  RAM write enable.
- waddr  out  10  RAM write address, equal to row*32 + col.
- wdata  out  CELL_W  RAM write data.

Behaviour:
- Reset (reset=0 at a rising edge): we=0, waddr=0, wdata=0, clear_done=0, oob_err=0, FIFO emptied, state=IDLE.
  - req_ready=0 while reset=0; busy=0.
- Handshake:
  - Transfer occurs on a rising edge with req_valid=1 and req_ready=1.
  - req_ready = ~full; it is combinational from the FIFO count.
  - Data must be held stable while valid=1 and ready=0.
- FIFO: push and pop in the same cycle are legal, and the count is unchanged. No push is possible when full. A pop from empty never occurs.
- State machine:
  - IDLE:
    - If clear_start=1, go to CLEAR. clear_start has priority over draining, and no pop occurs that cycle.
    - Otherwise, if the FIFO is non-empty, pop one entry. At the next edge, register we=1, waddr={row,col}, wdata=data.
    - If the popped row >= GRID_ROWS, set we=0 and oob_err=1 instead.
  - CLEAR:
    - A 10-bit counter runs 0..(GRID_ROWS*32-1), i.e. 0..767.
    - Each cycle: we=1, waddr=counter, wdata=CLEAR_VAL.
    - The FIFO still accepts requests but is not drained.
    - clear_start is ignored while in CLEAR.
    - After the write to address 767 is issued, return to IDLE with clear_done=1 for exactly one cycle.
- Outputs are registered.
- Latency:
  - A request accepted at edge E into an empty FIFO in IDLE is popped at edge E+1.
  - we is high during the cycle following edge E+1.
  - Sustained throughput is 1 write/cycle.
- A clear takes 768 write cycles. The first write appears the cycle after the clear_start edge.
- A reset in mid-clear or mid-drain aborts immediately: pending FIFO contents are discarded and no clear_done pulse is issued.
- we deasserts on every cycle with no write.

Optional Feature:
- Macro BOARD_WRITER_VBLANK_GATE_EN.
- When defined:
  - An input port in_vblank (1 bit) is added.
  - Pops and clear-counter advances occur only when in_vblank=1; otherwise we=0 and the state holds.
  - A clear spanning multiple blanking intervals resumes at the held counter value.
  - clear_start is still accepted during active video.
- When undefined:
  - The port is absent.
  - Writes are ungated, as described above.

Decomposition:
- Package snake_vga_pkg holds:
  - GRID_COLS, GRID_ROWS, TILE_ADDR_W=10;
  - typedef tile_t (logic [CELL_W-1:0]);
  - typedef struct cell_req_t {row, col, data};
  - enum bw_state_t {IDLE, CLEAR}.
- One sub-module, req_fifo:
  - parameterised synchronous FIFO of cell_req_t;
  - push/pop/full/empty/count.
- The address mapping and FSM stay in board_writer.

Test Plan:
- Reset held 3 cycles, then released -> we=0, req_ready=1, busy=0, oob_err=0.
- Single request row=5, col=7, data=0xA accepted at edge E -> the cycle after E+1 shows we=1, waddr=167, wdata=0xA, with we=0 afterwards.
- 6 back-to-back requests with FIFO_DEPTH=4 while the clear holds the drain -> req_ready drops after 4 accepts. After clear_done, 4 writes occur in order on consecutive cycles.
- clear_start pulse -> exactly 768 consecutive we=1 cycles with waddr 0..767 and wdata=0, then clear_done high for 1 cycle. A second clear_start mid-clear has no effect.
- Request row=24, col=3 -> no write is issued, oob_err=1 sticky until reset, and the following valid request is written normally.
- reset=0 at clear cycle 100 -> we=0 the next cycle, no clear_done, FIFO empty. With BOARD_WRITER_VBLANK_GATE_EN, toggling in_vblank pauses and resumes the counter without skipping addresses.
